// File: rtl/tick_gen_if.sv
// Stimulus/response bundle for tick_gen: switches and raw button in,
// tick strobe and conditioned button signals out.
interface tick_gen_if;
    logic [2:0] i_sw;
    logic       i_btn;
    logic       o_valid;
    logic       o_btn;
    logic       o_btn_press;

    modport master (
        output i_sw,
        output i_btn,
        input  o_valid,
        input  o_btn,
        input  o_btn_press
    );

    modport slave (
        input  i_sw,
        input  i_btn,
        output o_valid,
        output o_btn,
        output o_btn_press
    );
endinterface

// File: rtl/tick_gen.sv
// Tick strobe generator with four selectable periods, plus a two-flop
// synchronized, counter-debounced button with a rising-edge press pulse.
module tick_gen #(
    parameter int unsigned NB_COUNT   = 32,
    parameter int unsigned RATE0      = 2**23,
    parameter int unsigned RATE1      = 2**24,
    parameter int unsigned RATE2      = 2**25,
    parameter int unsigned RATE3      = 2**26,
    parameter int unsigned NB_DEB     = 20,
    parameter int unsigned DEB_CYCLES = 2**19
) (
    input  logic       clock,
    input  logic       i_reset,
    tick_gen_if.slave  bus
);

    localparam logic [NB_COUNT-1:0] LAST0    = NB_COUNT'(RATE0 - 1);
    localparam logic [NB_COUNT-1:0] LAST1    = NB_COUNT'(RATE1 - 1);
    localparam logic [NB_COUNT-1:0] LAST2    = NB_COUNT'(RATE2 - 1);
    localparam logic [NB_COUNT-1:0] LAST3    = NB_COUNT'(RATE3 - 1);
    localparam logic [NB_DEB-1:0]   DEB_LAST = NB_DEB'(DEB_CYCLES - 1);

    logic [NB_COUNT-1:0] cnt_q, cnt_d;
    logic [NB_COUNT-1:0] lim_last;
    logic                valid_q, valid_d;
    logic                sync1_q, sync2_q;
    logic [NB_DEB-1:0]   deb_q, deb_d;
    logic                btn_q, btn_d;
    logic                press_q, press_d;

    always_comb begin
        lim_last = LAST0;
        case (bus.i_sw[2:1])
            2'd0:    lim_last = LAST0;
            2'd1:    lim_last = LAST1;
            2'd2:    lim_last = LAST2;
            default: lim_last = LAST3;
        endcase
    end

    // >= rather than == so a drop to a shorter period wraps at once
    // instead of running the counter all the way around.
    always_comb begin
        cnt_d   = cnt_q + NB_COUNT'(1);
        valid_d = 1'b0;
        if (!bus.i_sw[0]) begin
            cnt_d = '0;
        end else if (cnt_q >= lim_last) begin
            cnt_d   = '0;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        deb_d   = deb_q;
        btn_d   = btn_q;
        press_d = 1'b0;
        if (sync2_q == btn_q) begin
            deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            btn_d   = sync2_q;
            press_d = sync2_q;
        end else begin
            deb_d = deb_q + NB_DEB'(1);
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= '0;
            btn_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sync1_q <= bus.i_btn;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            btn_q   <= btn_d;
            press_q <= press_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_btn       = btn_q;
    assign bus.o_btn_press = press_q;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: expected {valid, btn, press} per cycle is
// queued as each step is driven and compared just after the next edge.
module tb_tick_gen;
    logic clock = 1'b0;
    logic i_reset;
    int   checks   = 0;
    int   failures = 0;
    logic [2:0] exp_q[$];

    tick_gen_if bus ();

    tick_gen #(
        .NB_COUNT   (32),
        .RATE0      (4),
        .RATE1      (8),
        .RATE2      (16),
        .RATE3      (32),
        .NB_DEB     (20),
        .DEB_CYCLES (5)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] observed();
        return {bus.o_valid, bus.o_btn, bus.o_btn_press};
    endfunction

    task automatic compare(input string tag);
        logic [2:0] exp_v;
        logic [2:0] obs_v;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: observed=%b expected=<none queued>", tag, observed());
            return;
        end
        exp_v = exp_q.pop_front();
        obs_v = observed();
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s: observed valid/btn/press=%b expected=%b at %0t", tag, obs_v, exp_v, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic v, input logic b, input logic p);
        exp_q.push_back({v, b, p});
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    initial begin
        i_reset    = 1'b0;
        bus.i_sw   = 3'b000;
        bus.i_btn  = 1'b0;
        #1 i_reset = 1'b1;
        #1;
        exp_q.push_back(3'b000);
        compare("reset_state");
        repeat (2) @(posedge clock);
        #1 i_reset = 1'b0;

        // fixed rate 0: first strobe 4 edges after enable, then every 4
        bus.i_sw = 3'b001;
        for (int n = 1; n <= 40; n++) cyc("fixed_rate", (n % 4) == 0, 1'b0, 1'b0);

        // rate 3 up to counter 20, then drop to rate 0: fires on next edge
        bus.i_sw = 3'b111;
        for (int n = 1; n <= 20; n++) cyc("rate3_run", 1'b0, 1'b0, 1'b0);
        bus.i_sw = 3'b001;
        for (int n = 1; n <= 11; n++) cyc("rate_down", (n % 4) == 1, 1'b0, 1'b0);
        // counter now 2; switching up continues to 31
        bus.i_sw = 3'b111;
        for (int n = 1; n <= 30; n++) cyc("rate_up", n == 30, 1'b0, 1'b0);

        // enable toggle at counter 2
        bus.i_sw = 3'b001;
        for (int n = 1; n <= 2; n++) cyc("pre_disable", 1'b0, 1'b0, 1'b0);
        bus.i_sw = 3'b000;
        for (int n = 1; n <= 3; n++) cyc("disabled", 1'b0, 1'b0, 1'b0);
        bus.i_sw = 3'b001;
        for (int n = 1; n <= 8; n++) cyc("reenable", (n % 4) == 0, 1'b0, 1'b0);

        // clean press and release, ticks off
        bus.i_sw  = 3'b000;
        bus.i_btn = 1'b1;
        for (int n = 1; n <= 20; n++) cyc("press", 1'b0, n >= 7, n == 7);
        bus.i_btn = 1'b0;
        for (int n = 1; n <= 10; n++) cyc("release", 1'b0, n < 7, 1'b0);

        // bounce: 3 high, 2 low, never long enough to qualify
        for (int n = 0; n < 30; n++) begin
            bus.i_btn = (n % 5) < 3;
            cyc("bounce", 1'b0, 1'b0, 1'b0);
        end
        bus.i_btn = 1'b0;
        for (int n = 1; n <= 4; n++) cyc("bounce_settle", 1'b0, 1'b0, 1'b0);

        // reset mid-operation with o_btn = 1 and counter = 2
        bus.i_btn = 1'b1;
        for (int n = 1; n <= 9; n++) cyc("press2", 1'b0, n >= 7, n == 7);
        bus.i_sw = 3'b001;
        for (int n = 1; n <= 2; n++) cyc("pre_reset", 1'b0, 1'b1, 1'b0);
        #2 i_reset = 1'b1;
        #1;
        exp_q.push_back(3'b000);
        compare("async_reset");
        #1 i_reset = 1'b0;
        for (int n = 1; n <= 10; n++) cyc("post_reset", (n % 4) == 0, n >= 7, n == 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tick_gen.md
# tick_gen

Front-end timing stage for the LED shifter. It produces the one-cycle `o_valid` strobe that paces the shift rate, selected from four programmable periods and gated by an enable switch. It also delivers a synchronized, debounced button level and a one-cycle press pulse, so the shifter's button edge detector and `i_valid` input receive clean signals.

## Interface
Parameters:
- `NB_COUNT`, 32: width of the period counter.
- `RATE0`, 2**23: period of `o_valid`, in clocks, for rate select 0.
- `RATE1`, 2**24: period for rate select 1.
- `RATE2`, 2**25: period for rate select 2.
- `RATE3`, 2**26: period for rate select 3.
- `NB_DEB`, 20: width of the debounce counter.
- `DEB_CYCLES`, 2**19: number of stable clocks required before the button level is accepted.

Ports:
- `clock`, input, 1: single system clock, rising-edge.
- `i_reset`, input, 1: reset, asynchronous and active-high.
- `i_sw`, input, 3: `[0]` enable, `[2:1]` rate select (0 to 3).
- `i_btn`, input, 1: raw, asynchronous button.
- `o_valid`, output, 1: one-cycle tick strobe, registered.
- `o_btn`, output, 1: debounced button level, registered.
- `o_btn_press`, output, 1: one-cycle pulse on a debounced rising edge, registered.

## Operation
- Reset, asynchronous and applied immediately:
  - period counter = 0
  - `o_valid` = 0
  - both synchronizer flops = 0
  - debounce counter = 0
  - `o_btn` = 0
  - `o_btn_press` = 0
- `i_sw` is sampled every clock with no synchronizer. Switches are quasi-static, and a metastable sample only costs one tick of jitter.
- Limit `L` = RATE[`i_sw[2:1]`], taken combinationally from the current sample. Every `RATEn` must be ≥ 2 and < 2**`NB_COUNT`.
- Period counter behaviour:
  - `i_sw[0]` = 0: counter is forced to 0 and `o_valid` = 0. Any partial period is discarded.
  - `i_sw[0]` = 1 and counter ≥ L−1: counter goes to 0 and `o_valid` = 1 on the next cycle.
  - Otherwise: counter increments by 1 and `o_valid` = 0.
- The comparison is ≥, not ==. If the rate changes to a smaller limit mid-period, the strobe fires on the next edge and the counter wraps. The counter never runs past the limit, and it never wraps modulo 2**`NB_COUNT`.
- Button synchronizer: two flops, `i_btn` → s1 → s2.
- Debounce counter:
  - s2 == `o_btn`: debounce counter is cleared to 0.
  - Otherwise, when the counter == DEB_CYCLES−1: `o_btn` takes s2 and the counter clears.
  - Otherwise: the counter increments.
- Any bounce back to the accepted level restarts the qualification.
- `o_btn_press` = 1 for exactly the cycle following the edge at which `o_btn` goes 0→1. A 1→0 transition produces no pulse.
- The two halves are independent, so ticks and button activity can coincide freely.

## Timing
- `o_valid` pattern:
  - With enable held high from sampling edge k, the first `o_valid` is high during the cycle after edge k+L−1.
  - After that it repeats every L cycles.
  - Pulse width is always exactly 1 cycle.
  - It is never asserted on two consecutive cycles, because L ≥ 2.
- Enable dropped on the same edge a strobe would fire: no strobe, counter goes to 0.
- Rate change to a larger limit mid-period: counting continues to the new L−1.
- Button latency, stable input change to `o_btn` change: 2 synchronizer edges + DEB_CYCLES edges.
- `o_btn_press` asserts in the same cycle that `o_btn` reads 1.
- Glitches shorter than DEB_CYCLES clocks, as seen after synchronization, never change `o_btn`.
- Reset asserted mid-period or mid-debounce:
  - All outputs drop to 0 asynchronously.
  - After release the period restarts from 0 and `o_btn` = 0.
  - If the button is still held at release, it qualifies again after 2+DEB_CYCLES edges and produces one `o_btn_press`.

## Test plan
Use RATE0..3 = 4/8/16/32 and DEB_CYCLES = 5.
- **Fixed rate:** reset, then `i_sw` = 3'b001. `o_valid` first fires 4 edges after enable, then every 4 cycles, 1 cycle wide; 10 pulses are checked.
- **Rate switch:** run at rate 3 with counter = 20, then switch to rate 0. `o_valid` fires on the next cycle, then every 4 cycles. Switching 0→3 at counter 2 gives the next pulse when counter reaches 31.
- **Enable toggle:** drop enable at counter = 2 for 3 cycles, then re-raise. No pulse occurs while disabled, and the next pulse comes a full 4 cycles after re-enable.
- **Clean press:** hold `i_btn` = 1 for 20 cycles. `o_btn` rises 7 edges after the input change. `o_btn_press` is a single 1-cycle pulse. Release produces `o_btn` = 0 after 7 edges with no pulse.
- **Bounce:** toggle `i_btn` with high-times of 3 cycles and low-times of 2 cycles for 30 cycles. `o_btn` stays 0 and `o_btn_press` never asserts.
- **Reset mid-operation:** assert `i_reset` asynchronously between edges while the period counter = 2 and `o_btn` = 1. All outputs are 0 immediately. After release with the button held, `o_btn_press` pulses once, 7 edges later.
